// File: rtl/flow_rr_merger_if.sv
// Bundle of the flow merger's config, per-flow input, tagged output and status signals.
// The master side is the environment; the slave side is the merger.
interface flow_rr_merger_if #(
    parameter int FLUX   = 2,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 14
);
    localparam int TW = (FLUX > 1) ? $clog2(FLUX) : 1;

    logic                   cfg_write;
    logic [LEN_W+TW-1:0]    cfg_din;
    logic [FLUX*DATA_W-1:0] in_din;
    logic [FLUX-1:0]        in_write;
    logic [FLUX-1:0]        in_full;
    logic [DATA_W+TW-1:0]   out_din;
    logic                   out_write;
    logic [FLUX-1:0]        out_full;
    logic [FLUX-1:0]        flow_active;
    logic [FLUX-1:0]        flow_done;
    logic [1:0]             err;

    modport master (
        output cfg_write, cfg_din, in_din, in_write, out_full,
        input  in_full, out_din, out_write, flow_active, flow_done, err
    );

    modport slave (
        input  cfg_write, cfg_din, in_din, in_write, out_full,
        output in_full, out_din, out_write, flow_active, flow_done, err
    );
endinterface

// File: rtl/flow_rr_merger.sv
// Buffers FLUX untagged pel streams in per-flow FIFOs and merges them round-robin
// onto one {tag, pel} stream, counting a configured number of pels per flow.
module flow_rr_merger #(
    parameter int FLUX   = 2,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 14
) (
    input  logic             clk,
    input  logic             rst,
    flow_rr_merger_if.slave  bus
);
    localparam int TW = (FLUX > 1) ? $clog2(FLUX) : 1;
    localparam int AW = $clog2(DEPTH);

    logic [TW-1:0]        r_ptr;
    logic                 r_out_write;
    logic [DATA_W+TW-1:0] r_out_din;
    logic [1:0]           r_err;

    logic [TW-1:0]        w_cfg_tag;
    logic [LEN_W-1:0]     w_cfg_len;
    logic [FLUX-1:0]      w_elig;
    logic [FLUX-1:0]      w_full_vec;
    logic [FLUX-1:0]      w_active_vec;
    logic [FLUX-1:0]      w_done_vec;
    logic [FLUX-1:0]      w_cfg_ok_vec;
    logic [DATA_W-1:0]    w_head [FLUX];
    logic                 w_grant_valid;
    logic [TW-1:0]        w_grant_idx;
    logic                 w_push_err;
    logic                 w_cfg_err;

    assign w_cfg_tag = bus.cfg_din[LEN_W+TW-1:LEN_W];
    assign w_cfg_len = bus.cfg_din[LEN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < FLUX; gi++) begin : g_flow
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [AW-1:0]     r_wr_ptr;
            logic [AW-1:0]     r_rd_ptr;
            logic [AW:0]       r_cnt;
            logic              r_full;
            logic              r_active;
            logic              r_done;
            logic [LEN_W-1:0]  r_rem;
            logic              w_push;
            logic              w_pop;
            logic              w_cfg_ok;
            logic [AW:0]       w_cnt_next;

            // Full is taken from registered occupancy, so a pop never frees room for a same-cycle push.
            assign w_push     = bus.in_write[gi] & ~r_full;
            assign w_pop      = w_grant_valid && (w_grant_idx == TW'(gi));
            assign w_cfg_ok   = bus.cfg_write && (w_cfg_tag == TW'(gi)) && !r_active
                                && (w_cfg_len != '0);
            assign w_cnt_next = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= bus.in_din[gi*DATA_W +: DATA_W];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_cnt    <= '0;
                    r_full   <= 1'b0;
                    r_active <= 1'b0;
                    r_done   <= 1'b0;
                    r_rem    <= '0;
                end else begin
                    if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_cnt  <= w_cnt_next;
                    r_full <= (w_cnt_next == (AW+1)'(DEPTH));
                    r_done <= w_pop && (r_rem == LEN_W'(1));
                    if (w_cfg_ok) begin
                        r_rem    <= w_cfg_len;
                        r_active <= 1'b1;
                    end else if (w_pop) begin
                        r_rem <= r_rem - 1'b1;
                        if (r_rem == LEN_W'(1)) r_active <= 1'b0;
                    end
                end
            end

            assign w_head[gi]       = r_mem[r_rd_ptr];
            assign w_elig[gi]       = (r_cnt != '0) && r_active && !bus.out_full[gi];
            assign w_full_vec[gi]   = r_full;
            assign w_active_vec[gi] = r_active;
            assign w_done_vec[gi]   = r_done;
            assign w_cfg_ok_vec[gi] = w_cfg_ok;
        end
    endgenerate

    // Scan downward so the last hit wins: that is the first eligible flow after r_ptr.
    always_comb begin
        int          j;
        logic [TW-1:0] w_idx;
        j             = 0;
        w_idx         = '0;
        w_grant_valid = 1'b0;
        w_grant_idx   = r_ptr;
        for (int k = FLUX; k >= 1; k--) begin
            j     = (int'(r_ptr) + k) % FLUX;
            w_idx = TW'(j);
            if (w_elig[w_idx]) begin
                w_grant_valid = 1'b1;
                w_grant_idx   = w_idx;
            end
        end
    end

    assign w_push_err = |(bus.in_write & w_full_vec);
    assign w_cfg_err  = bus.cfg_write && !(|w_cfg_ok_vec);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= TW'(FLUX - 1);
            r_out_write <= 1'b0;
            r_out_din   <= '0;
            r_err       <= 2'b00;
        end else begin
            r_out_write <= w_grant_valid;
            if (w_grant_valid) begin
                r_ptr     <= w_grant_idx;
                r_out_din <= {w_grant_idx, w_head[w_grant_idx]};
            end
            r_err <= r_err | {w_cfg_err, w_push_err};
        end
    end

    assign bus.in_full     = w_full_vec;
    assign bus.flow_active = w_active_vec;
    assign bus.flow_done   = w_done_vec;
    assign bus.out_write   = r_out_write;
    assign bus.out_din     = r_out_din;
    assign bus.err         = r_err;
endmodule
